// File: rtl/alu_pkg.sv
// Shared definitions for the sequential bitwise logic unit.
//   - op encoding (3-bit) and the reserved encoding
//   - FSM state type used by the top level
//   - helper to classify an op as legal
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_AND  = 3'b000;
    localparam op_t OP_OR   = 3'b001;
    localparam op_t OP_XOR  = 3'b010;
    localparam op_t OP_NOR  = 3'b011;
    localparam op_t OP_ANDN = 3'b100;  // a & ~b
    localparam op_t OP_ORN  = 3'b101;  // a | ~b
    localparam op_t OP_XNOR = 3'b110;
    localparam op_t OP_RSVD = 3'b111;  // yields zero and flags illegal

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic logic op_is_legal(op_t op);
        return op != OP_RSVD;
    endfunction

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise function for one SLICE-bit slice of the operands.
// Ports:
//   op  in   3      operation select (alu_pkg encoding)
//   a   in   SLICE  operand A slice
//   b   in   SLICE  operand B slice
//   y   out  SLICE  f(op, a, b); zero for the reserved encoding
module logic_slice
    import alu_pkg::*;
#(
    parameter int unsigned SLICE = 16
) (
    input  op_t              op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_ANDN: y = a & ~b;
            OP_ORN:  y = a | ~b;
            OP_XNOR: y = ~(a ^ b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_logic_seq.sv
// Multi-cycle bitwise logic unit. Operands are latched on accept and processed
// SLICE bits per cycle, lowest slice first, so a WIDTH-bit op takes
// NSLICE = WIDTH/SLICE RUN cycles. Valid/ready handshake on both sides.
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset
//   in_valid   in   1      request present
//   in_ready   out  1      unit can accept a request (IDLE only)
//   op         in   3      operation select
//   a, b       in   WIDTH  operands, sampled only at the accept edge
//   out_valid  out  1      result available (DONE)
//   out_ready  in   1      consumer takes the result
//   result     out  WIDTH  operation result
//   zero       out  1      result == 0, meaningful while out_valid
//   illegal    out  1      op was the reserved encoding, meaningful while out_valid
module alu_logic_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SLICE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_slice
            $error("alu_logic_seq: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    op_t               op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;

    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  b_sl;
    logic [SLICE-1:0]  y_sl;
    logic              last_slice;

    // Only one slice function is instantiated; the counter steers operands to it.
    assign a_sl = a_q[idx_q*SLICE +: SLICE];
    assign b_sl = b_q[idx_q*SLICE +: SLICE];

    logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .op (op_q),
        .a  (a_sl),
        .b  (b_sl),
        .y  (y_sl)
    );

    assign last_slice = (idx_q == IDXW'(NSLICE - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            StIdle: begin
                // Held low while reset is asserted so nothing looks acceptable.
                in_ready = ~reset;
                if (in_valid) begin
                    op_d     = op;
                    a_d      = a;
                    b_d      = b;
                    result_d = '0;
                    idx_d    = '0;
                    state_d  = StRun;
                end
            end

            StRun: begin
                result_d[idx_q*SLICE +: SLICE] = y_sl;
                if (last_slice) begin
                    idx_d     = '0;
                    state_d   = StDone;
                    // Flags are computed from the fully assembled next result.
                    zero_d    = (result_d == '0);
                    illegal_d = ~op_is_legal(op_q);
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end

            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    // Flags are only meaningful while out_valid is high.
                    zero_d    = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            op_q      <= OP_AND;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule
